// File: rtl/disp_rdarb.sv
// Two-master AXI read arbiter: DISP (master 0) has priority over DRW (master 1),
// with a streak counter that forces a DRW grant after STARVE_N back-to-back DISP wins.
module disp_rdarb #(
    parameter int DW       = 64,
    parameter int AW       = 32,
    parameter int STARVE_N = 4
) (
    input  logic          ACLK,
    input  logic          ARESETN,

    input  logic [AW-1:0] M0_ARADDR,
    input  logic [7:0]    M0_ARLEN,
    input  logic          M0_ARVALID,
    output logic          M0_ARREADY,
    output logic [DW-1:0] M0_RDATA,
    output logic          M0_RLAST,
    output logic          M0_RVALID,
    input  logic          M0_RREADY,

    input  logic [AW-1:0] M1_ARADDR,
    input  logic [7:0]    M1_ARLEN,
    input  logic          M1_ARVALID,
    output logic          M1_ARREADY,
    output logic [DW-1:0] M1_RDATA,
    output logic          M1_RLAST,
    output logic          M1_RVALID,
    input  logic          M1_RREADY,

    output logic [AW-1:0] S_ARADDR,
    output logic [7:0]    S_ARLEN,
    output logic          S_ARVALID,
    input  logic          S_ARREADY,
    input  logic [DW-1:0] S_RDATA,
    input  logic          S_RLAST,
    input  logic          S_RVALID,
    output logic          S_RREADY,

    output logic [1:0]    GNT
);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    localparam logic [3:0] STREAK_MAX = 4'(STARVE_N);

    state_t     state_reg, state_next;
    logic [1:0] gnt_reg, gnt_next;
    logic [3:0] streak_reg, streak_next;

    logic [1:0] arvalid;
    logic [1:0] rready;
    logic [1:0] arready_out;
    logic [1:0] rvalid_out;
    logic [1:0] rlast_out;
    logic       sel;
    logic       addr_phase;
    logic       data_phase;

    assign arvalid = {M1_ARVALID, M0_ARVALID};
    assign rready  = {M1_RREADY, M0_RREADY};

    // Gating with ARESETN keeps every handshake output low while reset is held,
    // even before the state register has been cleared.
    assign sel        = gnt_reg[1];
    assign addr_phase = ARESETN && (state_reg == S_ADDR);
    assign data_phase = ARESETN && (state_reg == S_DATA);

    assign S_ARADDR  = sel ? M1_ARADDR : M0_ARADDR;
    assign S_ARLEN   = sel ? M1_ARLEN  : M0_ARLEN;
    assign S_ARVALID = addr_phase && arvalid[sel];
    assign S_RREADY  = data_phase && rready[sel];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_route
            assign arready_out[gi] = addr_phase && gnt_reg[gi] && S_ARREADY;
            assign rvalid_out[gi]  = data_phase && gnt_reg[gi] && S_RVALID;
            assign rlast_out[gi]   = data_phase && gnt_reg[gi] && S_RLAST;
        end
    endgenerate

    assign M0_ARREADY = arready_out[0];
    assign M0_RVALID  = rvalid_out[0];
    assign M0_RLAST   = rlast_out[0];
    assign M0_RDATA   = S_RDATA;
    assign M1_ARREADY = arready_out[1];
    assign M1_RVALID  = rvalid_out[1];
    assign M1_RLAST   = rlast_out[1];
    assign M1_RDATA   = S_RDATA;
    assign GNT        = gnt_reg;

    always_comb begin
        state_next  = state_reg;
        gnt_next    = gnt_reg;
        streak_next = streak_reg;
        case (state_reg)
            S_IDLE: begin
                if (arvalid != 2'b00) begin
                    state_next = S_ADDR;
                    if (arvalid[1] && (!arvalid[0] || streak_reg == STREAK_MAX)) begin
                        gnt_next    = 2'b10;
                        streak_next = 4'd0;
                    end else begin
                        gnt_next = 2'b01;
                        // The streak only grows while DRW is actually being held off.
                        if (!arvalid[1])
                            streak_next = 4'd0;
                        else if (streak_reg != STREAK_MAX)
                            streak_next = streak_reg + 4'd1;
                    end
                end
            end
            S_ADDR: begin
                if (S_ARVALID && S_ARREADY)
                    state_next = S_DATA;
            end
            S_DATA: begin
                if (S_RVALID && S_RREADY && S_RLAST) begin
                    state_next = S_IDLE;
                    gnt_next   = 2'b00;
                end
            end
            default: begin
                state_next = S_IDLE;
                gnt_next   = 2'b00;
            end
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_reg  <= S_IDLE;
            gnt_reg    <= 2'b00;
            streak_reg <= 4'd0;
        end else begin
            state_reg  <= state_next;
            gnt_reg    <= gnt_next;
            streak_reg <= streak_next;
        end
    end

endmodule

// File: tb/tb_disp_rdarb.sv
// Directed bench for disp_rdarb: a table of arbitration scenarios with expected
// grant order, plus hand sequences for reset, AR stall, backpressure and mid-burst reset.
module tb_disp_rdarb;

    localparam int DW = 64;
    localparam int AW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          aresetn;
    logic [AW-1:0] m0_araddr, m1_araddr, s_araddr;
    logic [7:0]    m0_arlen, m1_arlen, s_arlen;
    logic          m0_arvalid, m1_arvalid, s_arvalid;
    logic          m0_arready, m1_arready, s_arready;
    logic [DW-1:0] m0_rdata, m1_rdata, s_rdata;
    logic          m0_rlast, m1_rlast, s_rlast;
    logic          m0_rvalid, m1_rvalid, s_rvalid;
    logic          m0_rready, m1_rready, s_rready;
    logic [1:0]    gnt;

    disp_rdarb #(.DW(DW), .AW(AW), .STARVE_N(4)) dut (
        .ACLK(clk), .ARESETN(aresetn),
        .M0_ARADDR(m0_araddr), .M0_ARLEN(m0_arlen), .M0_ARVALID(m0_arvalid), .M0_ARREADY(m0_arready),
        .M0_RDATA(m0_rdata), .M0_RLAST(m0_rlast), .M0_RVALID(m0_rvalid), .M0_RREADY(m0_rready),
        .M1_ARADDR(m1_araddr), .M1_ARLEN(m1_arlen), .M1_ARVALID(m1_arvalid), .M1_ARREADY(m1_arready),
        .M1_RDATA(m1_rdata), .M1_RLAST(m1_rlast), .M1_RVALID(m1_rvalid), .M1_RREADY(m1_rready),
        .S_ARADDR(s_araddr), .S_ARLEN(s_arlen), .S_ARVALID(s_arvalid), .S_ARREADY(s_arready),
        .S_RDATA(s_rdata), .S_RLAST(s_rlast), .S_RVALID(s_rvalid), .S_RREADY(s_rready),
        .GNT(gnt)
    );

    // Each master keeps ARVALID high while it has bursts left to issue.
    int issued0 = 0, issued1 = 0;
    int target0 = 0, target1 = 0;
    logic [7:0] len0, len1;

    assign m0_arvalid = (target0 > issued0);
    assign m1_arvalid = (target1 > issued1);
    assign m0_araddr  = 32'h1000_0000 + (32'(issued0) << 8);
    assign m1_araddr  = 32'h2000_0000 + (32'(issued1) << 8);
    assign m0_arlen   = len0;
    assign m1_arlen   = len1;

    // VRAM model: beat k of a burst at base B returns {k, B+k}.
    logic       sl_busy = 1'b0;
    logic [7:0] sl_beat = 8'd0;
    logic [7:0] sl_len  = 8'd0;
    logic [31:0] sl_base = 32'd0;

    always @(posedge clk) begin
        if (!aresetn) begin
            sl_busy <= 1'b0;
            sl_beat <= 8'd0;
        end else if (!sl_busy) begin
            if (s_arvalid && s_arready) begin
                sl_busy <= 1'b1;
                sl_base <= s_araddr;
                sl_len  <= s_arlen;
                sl_beat <= 8'd0;
            end
        end else if (s_rready) begin
            if (sl_beat == sl_len) sl_busy <= 1'b0;
            else                   sl_beat <= sl_beat + 8'd1;
        end
    end

    assign s_rvalid = sl_busy;
    assign s_rlast  = sl_busy && (sl_beat == sl_len);
    assign s_rdata  = {24'h0, sl_beat, sl_base + {24'h0, sl_beat}};

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t      beats0[$];
    beat_t      beats1[$];
    logic [1:0] glog[$];
    logic [1:0] gnt_prev = 2'b00;
    int         cross_cnt = 0;

    always @(posedge clk) begin
        if (m0_arvalid && m0_arready) issued0 <= issued0 + 1;
        if (m1_arvalid && m1_arready) issued1 <= issued1 + 1;
        if (m0_rvalid && m0_rready) beats0.push_back('{m0_rdata, m0_rlast});
        if (m1_rvalid && m1_rready) beats1.push_back('{m1_rdata, m1_rlast});
        gnt_prev <= gnt;
        if (gnt_prev == 2'b00 && gnt != 2'b00) glog.push_back(gnt);
        if ((m1_rvalid && gnt != 2'b10) || (m0_rvalid && gnt != 2'b01))
            cross_cnt <= cross_cnt + 1;
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        aresetn = 1'b0;
        step();
        step();
        aresetn = 1'b1;
    endtask

    task automatic wait_done(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            step();
            if (issued0 == target0 && issued1 == target1 && gnt == 2'b00 && !sl_busy) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, 64'(ok), 64'd1);
    endtask

    task automatic check_beats(input int m, input int qs, input int bs, input int nb, input int len);
        int          sz;
        beat_t       b;
        logic [31:0] base;
        sz   = (m == 0) ? beats0.size() : beats1.size();
        base = (m == 0) ? 32'h1000_0000 : 32'h2000_0000;
        check($sformatf("m%0d_beat_count", m), 64'(sz - qs), 64'(nb * (len + 1)));
        for (int j = 0; j < nb; j++) begin
            for (int k = 0; k <= len; k++) begin
                int idx = qs + j * (len + 1) + k;
                if (idx < sz) begin
                    b = (m == 0) ? beats0[idx] : beats1[idx];
                    check($sformatf("m%0d_data b%0d k%0d", m, bs + j, k), b.data,
                          {24'h0, 8'(k), base + 32'((bs + j) * 256 + k)});
                    check($sformatf("m%0d_rlast b%0d k%0d", m, bs + j, k), 64'(b.last), 64'(k == len));
                end
            end
        end
    endtask

    typedef struct {
        int          n0;
        int          n1;
        int          cnt;
        logic [15:0] order;  // bit k set: grant k goes to DRW
    } vec_t;

    vec_t vecs[5];

    initial begin
        int  q0, q1, b0, b1, g0, c0;
        bit  seen;
        logic exp_rr;

        vecs[0] = '{1,  0, 1,  16'h0000};
        vecs[1] = '{0,  1, 1,  16'h0001};
        vecs[2] = '{6,  2, 8,  16'h0090};
        vecs[3] = '{2,  3, 5,  16'h001C};
        vecs[4] = '{10, 2, 12, 16'h0210};

        aresetn   = 1'b0;
        s_arready = 1'b1;
        m0_rready = 1'b1;
        m1_rready = 1'b1;
        len0      = 8'd7;
        len1      = 8'd3;

        // Reset held with DISP requesting, then a single 8-beat DISP burst.
        target0 = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            check("rst_gnt", 64'(gnt), 64'd0);
            check("rst_s_arvalid", 64'(s_arvalid), 64'd0);
            check("rst_m0_arready", 64'(m0_arready), 64'd0);
        end
        aresetn = 1'b1;
        step();
        check("single_gnt", 64'(gnt), 64'h1);
        check("single_s_arvalid", 64'(s_arvalid), 64'd1);
        check("single_s_araddr", 64'(s_araddr), 64'h1000_0000);
        check("single_s_arlen", 64'(s_arlen), 64'd7);
        check("single_m0_arready", 64'(m0_arready), 64'd1);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (m0_rvalid && m0_rlast && m0_rready) begin
                seen = 1'b1;
                break;
            end
        end
        check("single_last_seen", 64'(seen), 64'd1);
        step();
        check("single_gnt_after", 64'(gnt), 64'd0);
        check_beats(0, 0, 0, 1, 7);

        // Arbitration table.
        len0 = 8'd3;
        len1 = 8'd3;
        for (int v = 0; v < 5; v++) begin
            do_reset();
            q0 = beats0.size(); q1 = beats1.size();
            b0 = issued0;       b1 = issued1;
            g0 = glog.size();   c0 = cross_cnt;
            target0 = issued0 + vecs[v].n0;
            target1 = issued1 + vecs[v].n1;
            wait_done($sformatf("vec%0d_done", v));
            check($sformatf("vec%0d_grants", v), 64'(glog.size() - g0), 64'(vecs[v].cnt));
            for (int k = 0; k < vecs[v].cnt; k++) begin
                if (g0 + k < glog.size())
                    check($sformatf("vec%0d_grant%0d", v, k), 64'(glog[g0 + k]),
                          vecs[v].order[k] ? 64'h2 : 64'h1);
            end
            check($sformatf("vec%0d_cross", v), 64'(cross_cnt - c0), 64'd0);
            check_beats(0, q0, b0, vecs[v].n0, 3);
            check_beats(1, q1, b1, vecs[v].n1, 3);
        end

        // DRW burst with RREADY toggling every cycle.
        do_reset();
        len1 = 8'd7;
        q1 = beats1.size(); b1 = issued1;
        target1 = issued1 + 1;
        for (int i = 0; i < 200; i++) begin
            step();
            if (beats1.size() >= q1 + 8 && gnt == 2'b00) break;
            m1_rready = ~m1_rready;
            #1;
            exp_rr = (issued1 == target1 && beats1.size() < q1 + 8) ? m1_rready : 1'b0;
            check($sformatf("bp_s_rready c%0d", i), 64'(s_rready), 64'(exp_rr));
        end
        m1_rready = 1'b1;
        check_beats(1, q1, b1, 1, 7);

        // Slave holds ARREADY low for 10 cycles.
        do_reset();
        len0 = 8'd3;
        s_arready = 1'b0;
        q0 = beats0.size(); b0 = issued0;
        target0 = issued0 + 1;
        step();
        for (int i = 0; i < 10; i++) begin
            check("stall_s_arvalid", 64'(s_arvalid), 64'd1);
            check("stall_s_araddr", 64'(s_araddr), 64'(32'h1000_0000 + (32'(b0) << 8)));
            check("stall_gnt", 64'(gnt), 64'h1);
            check("stall_m0_arready", 64'(m0_arready), 64'd0);
            step();
        end
        s_arready = 1'b1;
        wait_done("stall_done");
        check_beats(0, q0, b0, 1, 3);

        // Reset after beat 3 of 8, then a fresh DRW burst.
        do_reset();
        len0 = 8'd7;
        q0 = beats0.size();
        target0 = issued0 + 1;
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (beats0.size() == q0 + 3) begin
                seen = 1'b1;
                break;
            end
        end
        check("midrst_three_beats", 64'(seen), 64'd1);
        aresetn = 1'b0;
        #1;
        check("midrst_m0_rvalid_in_rst", 64'(m0_rvalid), 64'd0);
        check("midrst_s_rready_in_rst", 64'(s_rready), 64'd0);
        step();
        check("midrst_gnt", 64'(gnt), 64'd0);
        check("midrst_m0_rvalid", 64'(m0_rvalid), 64'd0);
        aresetn = 1'b1;
        len1 = 8'd3;
        q1 = beats1.size(); b1 = issued1;
        target1 = issued1 + 1;
        step();
        check("midrst_m1_gnt", 64'(gnt), 64'h2);
        wait_done("midrst_done");
        check("midrst_m0_no_more", 64'(beats0.size() - q0), 64'd3);
        check_beats(1, q1, b1, 1, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
